// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-to-serial transmit stage for the PicoRV32 console port. Bytes arriving
// on the in_byte/in_byte_en strobe are buffered in a 2^FIFO_AW entry FIFO and
// sent as asynchronous frames (start, 8 data bits LSB first, stop) on tx, one
// bit every CLK_DIV clock cycles. Bytes offered while the FIFO is full are
// dropped and the sticky overflow flag is raised.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (frame becomes 11 bit times).
// With the macro undefined no parity state or logic exists.
//
// Parameters:
//   CLK_DIV     clock cycles per serial bit (2..65535)
//   FIFO_AW     FIFO address width, depth = 2^FIFO_AW
//
// Ports:
//   clk         system clock
//   resetn      synchronous, active-low reset
//   in_byte     byte to transmit (system.out_byte)
//   in_byte_en  single-cycle write strobe (system.out_byte_en)
//   tx          serial line, idle high, registered
//   busy        frame on the line or FIFO non-empty
//   fifo_full   FIFO holds 2^FIFO_AW bytes
//   fifo_count  bytes buffered, excluding the byte being shifted out
//   overflow    sticky drop flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       in_byte,
  input  logic             in_byte_en,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam int          DATA_W   = 8;
  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction
`endif

  // FIFO storage and pointers; pointers carry one extra wrap bit so that
  // full (difference == DEPTH) and empty (difference == 0) are distinct.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;

  // Transmitter control
  state_t            state;
  logic [15:0]       div_cnt;
  logic [2:0]        bit_idx;

  // Transmitter data (not reset: always reloaded before use)
  logic [DATA_W-1:0] shift_p0;
`ifdef UART_TX_PARITY_EN
  logic              par_p0;
`endif

  logic push;
  logic pop;
  logic fifo_nempty;
  logic bit_end;

  // Status outputs are pure functions of flops, so they change only on edges.
  assign fifo_count  = wr_ptr - rd_ptr;
  assign fifo_full   = fifo_count[FIFO_AW];
  assign fifo_nempty = (fifo_count != '0);
  assign busy        = (state != IDLE) || fifo_nempty;

  assign bit_end = (div_cnt == DIV_LAST);
  // A full FIFO rejects the write even if a pop frees a slot on the same edge.
  assign push    = in_byte_en && !fifo_full;
  assign pop     = fifo_nempty &&
                   ((state == IDLE) || ((state == STOP) && bit_end));

  // ---- write side: pointer and sticky overflow ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (in_byte_en && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---- data path: FIFO array, shift register, parity ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= in_byte;
    end
    if (pop) begin
      shift_p0 <= mem[rd_ptr[FIFO_AW-1:0]];
    end else if ((state == DATA) && bit_end) begin
      shift_p0 <= shift_p0 >> 1;
    end
`ifdef UART_TX_PARITY_EN
    if (pop) begin
      par_p0 <= even_parity(mem[rd_ptr[FIFO_AW-1:0]]);
    end
`endif
  end

  // ---- frame FSM: tx is loaded with the level of the state being entered ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_nempty) begin
            rd_ptr  <= rd_ptr + 1'b1;
            div_cnt <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift_p0[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_p0;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shift_p0[1] becomes shift_p0[0] on this same edge
              tx      <= shift_p0[1];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (fifo_nempty) begin
              rd_ptr <= rd_ptr + 1'b1;
              tx     <= 1'b0;
              state  <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        default: begin
          tx      <= 1'b1;
          div_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo with CLK_DIV=4, FIFO_AW=2.
// A reference model describes the transmitter as "cycles left in the current
// frame" plus a byte queue; each accepted byte is also pushed onto a
// scoreboard queue that an independent serial monitor pops as it decodes
// frames off the tx line.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME = NSLOT * CLK_DIV;

  logic             clk        = 1'b0;
  logic             resetn     = 1'b0;
  logic [7:0]       in_byte    = 8'h00;
  logic             in_byte_en = 1'b0;
  logic             tx;
  logic             busy;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_count;
  logic             overflow;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_byte    (in_byte),
    .in_byte_en (in_byte_en),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0] mq[$];       // bytes waiting in the FIFO
  logic [7:0] exp_q[$];    // scoreboard: accepted bytes not yet seen on tx
  int         tx_left = 0; // cycles remaining in the frame on the line
  logic [7:0] cur_byte = 8'h00;
  logic       m_ovf = 1'b0;

  int mon_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    int slot;
    if (tx_left == 0) return 1'b1;
    slot = (FRAME - tx_left) / CLK_DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return cur_byte[slot-1];
    if (slot == NSLOT - 1) return 1'b1;
    return ^cur_byte;
  endfunction

  // Reference model: advances once per rising edge using the applied inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        mq.delete();
        exp_q.delete();
        tx_left = 0;
        m_ovf   = 1'b0;
      end else begin
        int  s;
        bit  full;
        bit  do_pop;
        s      = mq.size();
        full   = (s == DEPTH);
        do_pop = (s != 0) && (tx_left <= 1);
        if (do_pop) begin
          cur_byte = mq.pop_front();
          tx_left  = FRAME;
        end else if (tx_left > 0) begin
          tx_left--;
        end
        if (in_byte_en) begin
          if (!full) begin
            mq.push_back(in_byte);
            exp_q.push_back(in_byte);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-level comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("tx",         32'(tx),         32'(model_tx()));
      chk("busy",       32'(busy),       32'((tx_left != 0) || (mq.size() != 0)));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      chk("overflow",   32'(overflow),   32'(m_ovf));
    end
  end

  // Serial monitor: decodes frames off tx and pops the scoreboard.
  initial begin
    bit         active = 1'b0;
    int         slot   = 0;
    int         scnt   = 0;
    logic       sval   = 1'b1;
    bit         sok    = 1'b1;
    logic [7:0] mbyte  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          if (tx == 1'b0) begin
            active = 1'b1;
            slot   = 0;
            scnt   = 1;
            sval   = 1'b0;
            sok    = 1'b1;
          end
        end else if (scnt == 0) begin
          sval = tx;
          sok  = 1'b1;
          scnt = 1;
        end else begin
          if (tx !== sval) sok = 1'b0;
          scnt++;
        end
        if (active && scnt == CLK_DIV) begin
          chk("bit_hold", 32'(sok), 32'd1);
          if (slot >= 1 && slot <= 8) mbyte[slot-1] = sval;
          if (slot == NSLOT - 1) begin
            logic [7:0] e;
            chk("stop_bit", 32'(sval), 32'd1);
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("frame_byte", 32'(mbyte), 32'(e));
            end
            mon_frames++;
            active = 1'b0;
          end else if (slot == 9) begin
            chk("parity_bit", 32'(sval), 32'(^mbyte));
          end
          slot++;
          scnt = 0;
        end
      end
    end
  end

  task automatic drive(input bit en, input logic [7:0] b);
    @(negedge clk);
    in_byte_en = en;
    in_byte    = b;
  endtask

  task automatic wait_idle(input int maxc, output int peak);
    bit done;
    done = 1'b0;
    peak = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      in_byte_en = 1'b0;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int peak;
    int f0;
    bit found;

    // Reset held with the strobe toggling
    resetn = 1'b0;
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h5A);
    @(negedge clk);
    resetn     = 1'b1;
    in_byte_en = 1'b0;
    repeat (3) drive(1'b0, 8'h00);

    // Single byte
    f0 = mon_frames;
    drive(1'b1, 8'h41);
    wait_idle(200, peak);
    chk("single_frames", 32'(mon_frames - f0), 32'd1);

    // Burst of three on consecutive cycles
    f0 = mon_frames;
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'h0F);
    wait_idle(400, peak);
    chk("burst_peak", 32'(peak), 32'd2);
    chk("burst_frames", 32'(mon_frames - f0), 32'd3);

    // Overflow: six consecutive pushes into a four-entry FIFO
    f0 = mon_frames;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom));
    wait_idle(600, peak);
    chk("ovf_frames", 32'(mon_frames - f0), 32'd5);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset during data bit 3
    drive(1'b1, 8'($urandom));
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_byte_en = 1'b0;
      if (tx_left != 0 && (FRAME - tx_left) / CLK_DIV == 4) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_data_bit3", 32'(found), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    f0 = mon_frames;
    repeat (80) drive(1'b0, 8'h00);
    chk("post_reset_frames", 32'(mon_frames - f0), 32'd0);
    chk("post_reset_ovf", 32'(overflow), 32'd0);

    // Random traffic: sparse, then heavy enough to overflow
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 39) == 0, 8'($urandom));
    for (int i = 0; i < 200; i++) drive($urandom_range(0, 2) == 0, 8'($urandom));
    wait_idle(2000, peak);
    repeat (4) drive(1'b0, 8'h00);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-to-serial transmit stage that sits directly downstream of the PicoRV32 `system` console port. It accepts the `out_byte`/`out_byte_en` strobe stream, buffers bytes in a small FIFO, and emits them as 8N1 asynchronous serial frames on `tx` at a fixed clock divisor. The FIFO absorbs firmware printf bursts without stalling the CPU. Bytes that arrive while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..65535.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `in_byte`  in  8  byte to transmit; connects to `system.out_byte`.
- `in_byte_en`  in  1  single-cycle write strobe; connects to `system.out_byte_en`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_full`  out  1  FIFO holds 2^FIFO_AW bytes.
- `fifo_count`  out  FIFO_AW+1  bytes currently buffered; excludes the byte being shifted.
- `overflow`  out  1  sticky; set when a byte is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0. FSM=IDLE; FIFO pointers, bit counter and divisor counter all 0.
- Push: on a clk edge with `in_byte_en`=1 and `fifo_full`=0 (pre-edge value), write `in_byte` and increment the count.
- Drop: `in_byte_en`=1 with `fifo_full`=1 drops the byte and sets `overflow`. This holds even if a pop happens on the same edge. `overflow` clears only on reset.
- Simultaneous push and pop with the FIFO not full: the count is unchanged and both pointers advance.
- Pointers wrap modulo 2^FIFO_AW. `fifo_count` is computed from pointers with an extra wrap bit; it never exceeds 2^FIFO_AW.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `fifo_count`!=0, pop the head into the shift register, clear the divisor counter, go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLK_DIV cycles, then shift right. After bit index 7 completes, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. In the final stop cycle, if `fifo_count`!=0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Data order: LSB first.
- Divisor counter: counts 0..CLK_DIV-1 and wraps. Bit state advances on the cycle where the counter equals CLK_DIV-1.
- Reset mid-frame: all state returns to reset values on the next edge, `tx` returns high immediately, and FIFO contents are discarded.

## Timing
- `tx` is a registered output; there is no combinational path from inputs to `tx`.
- Latency, push to start bit (FSM idle, FIFO empty): push at edge N; FSM pops at edge N+1; `tx`=0 is visible after edge N+1.
- Frame length: exactly 10·CLK_DIV cycles (11·CLK_DIV with parity).
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle.
- `fifo_full`, `fifo_count` and `busy` are registered and reflect post-edge state.
- `busy` falls on the edge where the FSM enters IDLE with an empty FIFO.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles, and the frame becomes 11·CLK_DIV cycles.
- Undefined: 8N1 only; no PARITY state or logic is synthesized.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_AW=2 unless stated.
- Reset: hold `resetn`=0 for 3 cycles with `in_byte_en` toggling -> `tx`=1, `fifo_count`=0, `overflow`=0, `busy`=0 throughout.
- Single byte: push 0x41 -> `tx` low 1 cycle after the push. Then 4 cycles each of 0, 1,0,0,0,0,0,1,0, and 1 for the stop bit. `busy` drops 40 cycles after the start bit begins.
- Burst: push 0x55, 0xAA, 0x0F on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between them; `fifo_count` peaks at 2.
- Overflow: push 6 bytes on consecutive cycles -> the first pop frees one slot, 4 are buffered, and the 6th byte is dropped. `overflow`=1 and stays 1 after all 5 transmitted frames finish.
- Reset mid-frame: assert `resetn`=0 during DATA bit 3 -> `tx`=1 on the next edge; after release, no further frames unless new bytes are pushed.
- Parity (`UART_TX_PARITY_EN` defined): push 0x07 -> parity bit 1 is held for 4 cycles before the stop bit, and the frame is 44 cycles.
